// File: rtl/mc_ctrl_unit.sv
// ---------------------------------------------------------------------------
// mc_ctrl_unit -- multi-cycle MIPS control unit
//
// Sequences each instruction through fetch, decode, execute, memory and
// writeback states. All datapath controls are decoded from the current state.
// The unit handshakes with a variable-latency memory through memReady. A
// wait-state watchdog traps into an absorbing FAULT state when a memory
// access stalls for too long.
//
// Build option:
//   MC_CTRL_JUMP_EN  when defined, opcode 000010 (j) executes through the
//                    JUMP state. When undefined, j is treated as an illegal
//                    opcode.
//
// Parameters:
//   MEM_TIMEOUT  maximum number of consecutive memReady-low cycles allowed in
//                a memory state. 0 disables the watchdog.
//
// Ports:
//   clk, rst_n    rising-edge clock, asynchronous active-low reset
//   opcode[5:0]   IR[31:26]
//   zero          ALU zero flag (beq)
//   memReady      memory completes the current access this cycle
//   pcEn, iorD, memRead, memWrite, irWrite, regWrite    enables / address select
//   regDst, memToReg, aluSrcA, aluSrcB[1:0], aluOp[1:0],
//   pcSource[1:0]                                       datapath selects
//   state[3:0]    current state (debug)
//   instrDone     pulse in the final cycle of each instruction
//   illegalOp     pulse on an unsupported opcode
//   memFault      watchdog fault flag; held until reset
// ---------------------------------------------------------------------------
module mc_ctrl_unit #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       memReady,
  output logic       pcEn,
  output logic       iorD,
  output logic       memRead,
  output logic       memWrite,
  output logic       irWrite,
  output logic       regWrite,
  output logic       regDst,
  output logic       memToReg,
  output logic       aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [1:0] aluOp,
  output logic [1:0] pcSource,
  output logic [3:0] state,
  output logic       instrDone,
  output logic       illegalOp,
  output logic       memFault
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    RWB    = 4'd7,
    BRANCH = 4'd8,
    ADDIEX = 4'd9,
    ADDIWB = 4'd10,
    JUMP   = 4'd11,
    FAULT  = 4'd12
  } stateT;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // A zero-width counter is not legal, so keep at least one bit even when
  // the watchdog is disabled.
  localparam int CNT_W   = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam int LIMIT_I = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;
  localparam logic [CNT_W-1:0] LIMIT = LIMIT_I[CNT_W-1:0];
  localparam logic WDOG_EN = (MEM_TIMEOUT > 0);

  stateT            stateReg, stateNext;
  logic [CNT_W-1:0] cntReg, cntNext;
  logic             inMemState;
  logic             timeout;

  // ---------------------------------------------------------------------
  // State and watchdog registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateReg <= FETCH;
      cntReg   <= '0;
    end else begin
      stateReg <= stateNext;
      cntReg   <= cntNext;
    end
  end

  // The counter is held at zero outside the memory states. Every exit from
  // a memory state into another one happens on memReady=1, which also
  // clears it. As a result, each memory state is always entered with a
  // count of zero.
  always_comb begin
    inMemState = (stateReg == FETCH) || (stateReg == MEMRD) || (stateReg == MEMWR);
    if (!inMemState || memReady) begin
      cntNext = '0;
    end else begin
      cntNext = cntReg + 1'b1;
    end
    timeout = WDOG_EN && inMemState && !memReady && (cntReg == LIMIT);
  end

  // ---------------------------------------------------------------------
  // Next-state logic and output decode
  // ---------------------------------------------------------------------
  always_comb begin
    stateNext = FETCH;
    pcEn      = 1'b0;
    iorD      = 1'b0;
    memRead   = 1'b0;
    memWrite  = 1'b0;
    irWrite   = 1'b0;
    regWrite  = 1'b0;
    regDst    = 1'b0;
    memToReg  = 1'b0;
    aluSrcA   = 1'b0;
    aluSrcB   = 2'b00;
    aluOp     = 2'b00;
    pcSource  = 2'b00;
    instrDone = 1'b0;
    illegalOp = 1'b0;

    case (stateReg)
      FETCH: begin
        memRead   = 1'b1;
        aluSrcB   = 2'b01;
        irWrite   = memReady;
        pcEn      = memReady;
        stateNext = memReady ? DECODE : FETCH;
      end
      DECODE: begin
        aluSrcB = 2'b11;
        case (opcode)
          OP_RTYPE:      stateNext = EXEC;
          OP_LW, OP_SW:  stateNext = MEMADR;
          OP_BEQ:        stateNext = BRANCH;
          OP_ADDI:       stateNext = ADDIEX;
`ifdef MC_CTRL_JUMP_EN
          OP_J:          stateNext = JUMP;
`endif
          default: begin
            // Unsupported opcode retires immediately as a NOP.
            illegalOp = 1'b1;
            instrDone = 1'b1;
            stateNext = FETCH;
          end
        endcase
      end
      MEMADR: begin
        aluSrcA   = 1'b1;
        aluSrcB   = 2'b10;
        stateNext = (opcode == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        memRead   = 1'b1;
        iorD      = 1'b1;
        stateNext = memReady ? MEMWB : MEMRD;
      end
      MEMWB: begin
        memToReg  = 1'b1;
        regWrite  = 1'b1;
        instrDone = 1'b1;
        stateNext = FETCH;
      end
      MEMWR: begin
        memWrite  = 1'b1;
        iorD      = 1'b1;
        instrDone = memReady;
        stateNext = memReady ? FETCH : MEMWR;
      end
      EXEC: begin
        aluSrcA   = 1'b1;
        aluOp     = 2'b10;
        stateNext = RWB;
      end
      RWB: begin
        regDst    = 1'b1;
        regWrite  = 1'b1;
        instrDone = 1'b1;
        stateNext = FETCH;
      end
      BRANCH: begin
        aluSrcA   = 1'b1;
        aluOp     = 2'b01;
        pcSource  = 2'b01;
        pcEn      = zero;
        instrDone = 1'b1;
        stateNext = FETCH;
      end
      ADDIEX: begin
        aluSrcA   = 1'b1;
        aluSrcB   = 2'b10;
        stateNext = ADDIWB;
      end
      ADDIWB: begin
        regWrite  = 1'b1;
        instrDone = 1'b1;
        stateNext = FETCH;
      end
`ifdef MC_CTRL_JUMP_EN
      JUMP: begin
        pcSource  = 2'b10;
        pcEn      = 1'b1;
        instrDone = 1'b1;
        stateNext = FETCH;
      end
`endif
      FAULT: begin
        stateNext = FAULT;
      end
      default: begin
        // Unused codes (and JUMP when jumps are disabled) recover to FETCH.
        stateNext = FETCH;
      end
    endcase

    // A stalled access that hits the limit overrides the hold.
    if (timeout) begin
      stateNext = FAULT;
    end
  end

  assign state    = stateReg;
  assign memFault = (stateReg == FAULT);

endmodule

// File: tb/tb_mc_ctrl_unit.sv
// ---------------------------------------------------------------------------
// tb_mc_ctrl_unit -- directed testbench for mc_ctrl_unit (MEM_TIMEOUT = 4)
//
// Each step drives opcode/zero/memReady and checks the state plus the
// packed control word. It then advances one clock. The control word packs:
//   pcEn iorD memRead memWrite irWrite regWrite regDst memToReg aluSrcA
//   _ aluSrcB _ aluOp _ pcSource _ instrDone illegalOp memFault
// ---------------------------------------------------------------------------
module tb_mc_ctrl_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       zero;
  logic       memReady;
  logic       pcEn, iorD, memRead, memWrite, irWrite, regWrite;
  logic       regDst, memToReg, aluSrcA;
  logic [1:0] aluSrcB, aluOp, pcSource;
  logic [3:0] state;
  logic       instrDone, illegalOp, memFault;
  logic [17:0] ctl;

  int total = 0;
  int bad   = 0;

  // Hand-derived control words, one per state and condition.
  localparam logic [17:0] W_F1     = 18'b101010000_01_00_00_000; // FETCH, ready
  localparam logic [17:0] W_F0     = 18'b001000000_01_00_00_000; // FETCH, waiting
  localparam logic [17:0] W_DEC    = 18'b000000000_11_00_00_000;
  localparam logic [17:0] W_DECILL = 18'b000000000_11_00_00_110;
  localparam logic [17:0] W_MEMADR = 18'b000000001_10_00_00_000;
  localparam logic [17:0] W_MEMRD  = 18'b011000000_00_00_00_000;
  localparam logic [17:0] W_MEMWB  = 18'b000001010_00_00_00_100;
  localparam logic [17:0] W_MEMWR1 = 18'b010100000_00_00_00_100;
  localparam logic [17:0] W_MEMWR0 = 18'b010100000_00_00_00_000;
  localparam logic [17:0] W_EXEC   = 18'b000000001_00_10_00_000;
  localparam logic [17:0] W_RWB    = 18'b000001100_00_00_00_100;
  localparam logic [17:0] W_BRZ1   = 18'b100000001_00_01_01_100;
  localparam logic [17:0] W_BRZ0   = 18'b000000001_00_01_01_100;
  localparam logic [17:0] W_ADDIWB = 18'b000001000_00_00_00_100;
  localparam logic [17:0] W_FAULT  = 18'b000000000_00_00_00_001;
`ifdef MC_CTRL_JUMP_EN
  localparam logic [17:0] W_JUMP   = 18'b100000000_00_00_10_100;
`endif

  mc_ctrl_unit #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .memReady(memReady),
    .pcEn(pcEn), .iorD(iorD), .memRead(memRead), .memWrite(memWrite),
    .irWrite(irWrite), .regWrite(regWrite), .regDst(regDst), .memToReg(memToReg),
    .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .aluOp(aluOp), .pcSource(pcSource),
    .state(state), .instrDone(instrDone), .illegalOp(illegalOp), .memFault(memFault)
  );

  always #5 clk = ~clk;

  assign ctl = {pcEn, iorD, memRead, memWrite, irWrite, regWrite, regDst, memToReg,
                aluSrcA, aluSrcB, aluOp, pcSource, instrDone, illegalOp, memFault};

  task automatic chk(input string tag, input logic [17:0] obs, input logic [17:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
    $display("t=%0t %s observed=%b expected=%b", $time, tag, obs, exp);
  endtask

  // Called just after a rising edge: apply inputs, check, advance one cycle.
  task automatic step(input string tag, input logic [5:0] op, input logic z,
                      input logic rdy, input logic [3:0] es, input logic [17:0] ec);
    opcode   = op;
    zero     = z;
    memReady = rdy;
    #1;
    chk({tag, ".state"}, {14'd0, state}, {14'd0, es});
    chk({tag, ".ctl"}, ctl, ec);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n    = 1'b0;
    opcode   = 6'd0;
    zero     = 1'b0;
    memReady = 1'b0;
    #3;
    chk("reset.state", {14'd0, state}, 18'd0);
    chk("reset.ctl", ctl, W_F0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // R-type: 0,1,6,7
    step("r.fetch",  6'b000000, 0, 1, 4'd0, W_F1);
    step("r.decode", 6'b000000, 0, 1, 4'd1, W_DEC);
    step("r.exec",   6'b000000, 0, 1, 4'd6, W_EXEC);
    step("r.rwb",    6'b000000, 0, 1, 4'd7, W_RWB);

    // lw with 3 wait states in MEMRD: 8 cycles total
    step("lw.fetch",  6'b100011, 0, 1, 4'd0, W_F1);
    step("lw.decode", 6'b100011, 0, 1, 4'd1, W_DEC);
    step("lw.memadr", 6'b100011, 0, 1, 4'd2, W_MEMADR);
    step("lw.memrdw1", 6'b100011, 0, 0, 4'd3, W_MEMRD);
    step("lw.memrdw2", 6'b100011, 0, 0, 4'd3, W_MEMRD);
    step("lw.memrdw3", 6'b100011, 0, 0, 4'd3, W_MEMRD);
    step("lw.memrd",  6'b100011, 0, 1, 4'd3, W_MEMRD);
    step("lw.memwb",  6'b100011, 0, 1, 4'd4, W_MEMWB);

    // sw with one wait state
    step("sw.fetch",  6'b101011, 0, 1, 4'd0, W_F1);
    step("sw.decode", 6'b101011, 0, 1, 4'd1, W_DEC);
    step("sw.memadr", 6'b101011, 0, 1, 4'd2, W_MEMADR);
    step("sw.memwrw", 6'b101011, 0, 0, 4'd5, W_MEMWR0);
    step("sw.memwr",  6'b101011, 0, 1, 4'd5, W_MEMWR1);

    // beq taken, then not taken
    step("beq1.fetch",  6'b000100, 1, 1, 4'd0, W_F1);
    step("beq1.decode", 6'b000100, 1, 1, 4'd1, W_DEC);
    step("beq1.branch", 6'b000100, 1, 1, 4'd8, W_BRZ1);
    step("beq0.fetch",  6'b000100, 0, 1, 4'd0, W_F1);
    step("beq0.decode", 6'b000100, 0, 1, 4'd1, W_DEC);
    step("beq0.branch", 6'b000100, 0, 1, 4'd8, W_BRZ0);

    // addi
    step("addi.fetch",  6'b001000, 0, 1, 4'd0, W_F1);
    step("addi.decode", 6'b001000, 0, 1, 4'd1, W_DEC);
    step("addi.ex",     6'b001000, 0, 1, 4'd9, W_MEMADR);
    step("addi.wb",     6'b001000, 0, 1, 4'd10, W_ADDIWB);

    // illegal opcode retires in DECODE
    step("ill.fetch",  6'b111111, 0, 1, 4'd0, W_F1);
    step("ill.decode", 6'b111111, 0, 1, 4'd1, W_DECILL);

    // j
    step("j.fetch", 6'b000010, 0, 1, 4'd0, W_F1);
`ifdef MC_CTRL_JUMP_EN
    step("j.decode", 6'b000010, 0, 1, 4'd1, W_DEC);
    step("j.jump",   6'b000010, 0, 1, 4'd11, W_JUMP);
`else
    step("j.decode", 6'b000010, 0, 1, 4'd1, W_DECILL);
`endif

    // Watchdog: 4 stalled FETCH cycles -> FAULT, absorbing
    step("wd.f1", 6'b000000, 0, 0, 4'd0, W_F0);
    step("wd.f2", 6'b000000, 0, 0, 4'd0, W_F0);
    step("wd.f3", 6'b000000, 0, 0, 4'd0, W_F0);
    step("wd.f4", 6'b000000, 0, 0, 4'd0, W_F0);
    step("wd.fault1", 6'b000000, 0, 1, 4'd12, W_FAULT);
    step("wd.fault2", 6'b000000, 0, 1, 4'd12, W_FAULT);

    // Asynchronous reset clears the fault without a clock edge
    rst_n = 1'b0;
    #1;
    chk("wd.rst.state", {14'd0, state}, 18'd0);
    chk("wd.rst.ctl", ctl, W_F1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Normal operation resumes after the fault is cleared
    step("post.fetch",  6'b000000, 0, 1, 4'd0, W_F1);
    step("post.decode", 6'b000000, 0, 1, 4'd1, W_DEC);
    step("post.exec",   6'b000000, 0, 1, 4'd6, W_EXEC);
    step("post.rwb",    6'b000000, 0, 1, 4'd7, W_RWB);
    step("post.fetch2", 6'b000000, 0, 1, 4'd0, W_F1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
